// File: rtl/leve_axi_pkg.sv
// Shared AXI read-channel types and the instruction-memory target FSM states.
package leve_axi_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        RESP
    } imem_st_t;

endpackage

// File: rtl/AXIR.sv
// AXI read-only channel bundle between an instruction-fetch initiator and a memory target.
interface AXIR;

    logic                            ARVALID;
    logic                            ARREADY;
    logic [leve_axi_pkg::XLEN-1:0]   ARADDR;
    logic [7:0]                      ARLEN;
    logic [1:0]                      ARBURST;
    logic                            RVALID;
    logic                            RREADY;
    logic [31:0]                     RDATA;
    logic [1:0]                      RRESP;
    logic                            RLAST;

    modport targ (
        input  ARVALID, ARADDR, ARLEN, ARBURST, RREADY,
        output ARREADY, RVALID, RDATA, RRESP, RLAST
    );

    modport init (
        output ARVALID, ARADDR, ARLEN, ARBURST, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP, RLAST
    );

endinterface

// File: rtl/leve_sram_sp.sv
// Single-port synchronous-read SRAM, 32 bits by DEPTH; dout holds its value while re is low.
module leve_sram_sp #(
    parameter int unsigned DEPTH     = 4096,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] addr,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) dout <= mem[addr];
    end

endmodule

// File: rtl/leve1_imem_targ.sv
// AXI read target serving instruction fetches from on-chip SRAM, one burst at a time.
// Optional per-beat wait states are compiled in with LEVE_IMEM_WAIT_EN.
module leve1_imem_targ
    import leve_axi_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter string       INIT_FILE = "",
    parameter int unsigned RD_WAIT   = 2
) (
    input logic CLK,
    input logic RST,
    AXIR.targ   RIT
);

    localparam int unsigned AW = $clog2(DEPTH);

    imem_st_t        state_q, state_d;
    imem_st_t        beat_st;
    logic            arready_q, arready_d;
    logic            acc_q, acc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    burst_t          burst_q, burst_d;
    resp_t           err_q, err_d;
    resp_t           ar_err;
    logic            last_beat;
    logic            sram_re;
    logic [31:0]     sram_dout;

`ifdef LEVE_IMEM_WAIT_EN
    localparam int unsigned WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    logic [WW-1:0] wait_q, wait_d;
    assign beat_st = (RD_WAIT == 0) ? RESP : WAIT;
`else
    logic unused_rd_wait;
    assign unused_rd_wait = (RD_WAIT != 0);
    assign beat_st = RESP;
`endif

    assign last_beat = (cnt_q == 8'd0);

    // Misalignment and unsupported bursts take priority over the range check.
    always_comb begin
        ar_err = OKAY;
        if (RIT.ARADDR[1:0] != 2'b00 || RIT.ARBURST > 2'd1) begin
            ar_err = SLVERR;
        end else if (|RIT.ARADDR[XLEN-1:AW+2]) begin
            ar_err = DECERR;
        end
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        err_d     = err_q;
        sram_re   = 1'b0;
`ifdef LEVE_IMEM_WAIT_EN
        wait_d    = wait_q;
`endif
        unique case (state_q)
            IDLE: begin
                // acc_q marks the cycle between AR acceptance and the SRAM read.
                if (acc_q) begin
                    acc_d   = 1'b0;
                    state_d = READ;
                end else if (arready_q && RIT.ARVALID) begin
                    addr_d    = RIT.ARADDR;
                    cnt_d     = RIT.ARLEN;
                    burst_d   = burst_t'(RIT.ARBURST);
                    err_d     = ar_err;
                    acc_d     = 1'b1;
                    arready_d = 1'b0;
                end else begin
                    arready_d = 1'b1;
                end
            end
            READ: begin
                sram_re = (err_q == OKAY);
                state_d = beat_st;
`ifdef LEVE_IMEM_WAIT_EN
                wait_d  = WW'(RD_WAIT - 1);
`endif
            end
`ifdef LEVE_IMEM_WAIT_EN
            WAIT: begin
                if (wait_q == '0) state_d = RESP;
                else              wait_d  = wait_q - WW'(1);
            end
`endif
            RESP: begin
                if (RIT.RREADY) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        if (burst_q == INCR) addr_d = addr_q + XLEN'(4);
                        sram_re = (err_q == OKAY);
                        state_d = beat_st;
`ifdef LEVE_IMEM_WAIT_EN
                        wait_d  = WW'(RD_WAIT - 1);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            acc_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            burst_q   <= FIXED;
            err_q     <= OKAY;
`ifdef LEVE_IMEM_WAIT_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
`ifdef LEVE_IMEM_WAIT_EN
            wait_q    <= wait_d;
`endif
        end
    end

    // Read address follows the next-state address so a handshake can fetch the next beat at once.
    leve_sram_sp #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk  (CLK),
        .re   (sram_re),
        .addr (addr_d[AW+1:2]),
        .dout (sram_dout)
    );

    assign RIT.ARREADY = arready_q;
    assign RIT.RVALID  = (state_q == RESP);
    assign RIT.RDATA   = (state_q == RESP && err_q == OKAY) ? sram_dout : 32'd0;
    assign RIT.RRESP   = (state_q == RESP) ? err_q : OKAY;
    assign RIT.RLAST   = (state_q == RESP) && last_beat;

endmodule

// File: tb/tb_leve1_imem_targ.sv
// Self-checking bench for leve1_imem_targ against a word-array reference model.
module tb_leve1_imem_targ;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned RD_WAIT = 2;
`ifdef LEVE_IMEM_WAIT_EN
    localparam int WAITC = RD_WAIT;
`else
    localparam int WAITC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    AXIR ax ();

    leve1_imem_targ #(
        .DEPTH     (DEPTH),
        .INIT_FILE (""),
        .RD_WAIT   (RD_WAIT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .RIT (ax)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          pat_idx     = 0;
    logic [31:0] mem_model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_err(input logic [31:0] a, input logic [1:0] b);
        if (a[1:0] != 2'b00 || b > 2'd1) return 2'b10;
        if ((a >> 2) >= DEPTH)           return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] a, input logic [1:0] b, input int i);
        logic [31:0] ad;
        if (m_err(a, b) != 2'b00) return 32'd0;
        ad = (b == 2'd1) ? a + 32'(4 * i) : a;
        return mem_model[int'((ad >> 2) % DEPTH)];
    endfunction

    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random
    function automatic logic rr(input int mode);
        int p;
        p = pat_idx % 4;
        pat_idx++;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (p == 0 || p == 3);
        return 1'($urandom % 2);
    endfunction

    task automatic burst(input logic [31:0] a, input int len, input logic [1:0] b,
                         input int mode, input int abort_beat);
        int       g;
        logic     hs;
        logic [1:0] e;
        e = m_err(a, b);
        ax.ARADDR  = a;
        ax.ARLEN   = 8'(len);
        ax.ARBURST = b;
        ax.ARVALID = 1'b1;
        g = 0;
        while (ax.ARREADY !== 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
        end
        chk("ar_ready", 32'(ax.ARREADY), 32'd1);
        @(negedge clk);
        ax.ARVALID = 1'b0;
        chk("ar_drop", 32'(ax.ARREADY), 32'd0);
        for (int i = 0; i <= len; i++) begin
            g = 0;
            while (ax.RVALID !== 1'b1 && g < 64) begin
                @(negedge clk);
                g++;
            end
            chk(i == 0 ? "first_lat" : "beat_gap", 32'(g), 32'(i == 0 ? 2 + WAITC : WAITC));
            if (i == abort_beat) begin
                rst = 1'b1;
                #1;
                chk("rst_rvalid", 32'(ax.RVALID), 32'd0);
                chk("rst_rlast", 32'(ax.RLAST), 32'd0);
                chk("rst_arready", 32'(ax.ARREADY), 32'd0);
                chk("rst_rdata", ax.RDATA, 32'd0);
                ax.RREADY = 1'b0;
                return;
            end
            hs = 1'b0;
            g  = 0;
            while (!hs && g < 64) begin
                chk("rvalid", 32'(ax.RVALID), 32'd1);
                chk("rdata", ax.RDATA, m_data(a, b, i));
                chk("rresp", 32'(ax.RRESP), 32'(e));
                chk("rlast", 32'(ax.RLAST), 32'(i == len));
                chk("ar_held", 32'(ax.ARREADY), 32'd0);
                ax.RREADY = rr(mode);
                hs = ax.RREADY;
                @(negedge clk);
                g++;
            end
            chk("r_handshake", 32'(hs), 32'd1);
        end
        ax.RREADY = 1'b0;
        chk("end_rvalid", 32'(ax.RVALID), 32'd0);
        chk("end_rlast", 32'(ax.RLAST), 32'd0);
        chk("end_arready", 32'(ax.ARREADY), 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rb;
        ax.ARVALID = 1'b0;
        ax.ARADDR  = '0;
        ax.ARLEN   = '0;
        ax.ARBURST = '0;
        ax.RREADY  = 1'b0;
        for (int j = 0; j < int'(DEPTH); j++) mem_model[j] = $urandom;
        mem_model[0] = 32'h0000_0013;
        for (int j = 0; j < int'(DEPTH); j++) dut.u_sram.mem[j] = mem_model[j];

        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(ax.ARREADY), 32'd0);
        chk("rst_rvalid", 32'(ax.RVALID), 32'd0);
        chk("rst_rlast", 32'(ax.RLAST), 32'd0);
        chk("rst_rresp", 32'(ax.RRESP), 32'd0);
        chk("rst_rdata", ax.RDATA, 32'd0);
        rst = 1'b0;
        #1;
        chk("arready_pre", 32'(ax.ARREADY), 32'd0);
        @(negedge clk);
        chk("arready_rise", 32'(ax.ARREADY), 32'd1);

        burst(32'h0, 0, 2'd1, 0, -1);
        burst(32'h100, 3, 2'd1, 0, -1);
        burst(32'h100, 3, 2'd1, 1, -1);
        burst(32'h2, 0, 2'd1, 0, -1);
        burst(32'(DEPTH * 4), 1, 2'd1, 2, -1);
        burst(32'h40, 2, 2'd2, 0, -1);
        burst(32'h20, 2, 2'd0, 1, -1);
        burst(32'((DEPTH - 2) * 4), 3, 2'd1, 0, -1);
        burst(32'hFFFF_FFF8, 2, 2'd1, 0, -1);

        for (int n = 0; n < 25; n++) begin
            ra = 32'($urandom_range(0, DEPTH * 4 + 32));
            if ($urandom % 4 != 0) ra[1:0] = 2'b00;
            rb = ($urandom % 5 == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom % 2);
            burst(ra, $urandom_range(0, 7), rb, 2, -1);
        end

        burst(32'h0, 7, 2'd1, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        burst(32'h0, 0, 2'd1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
